// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin arbiter sharing one UART TX top among NUM_REQ requesters
module uart_tx_scheduler #(
    parameter  int in_width     = 8,
    parameter  int NUM_REQ      = 4,
    parameter  int GAP_CYCLES   = 0,
    parameter  int BUSY_TIMEOUT = 16,
    localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*in_width-1:0] req_data,
    input  logic [NUM_REQ-1:0]          req_parity_en,
    input  logic [NUM_REQ-1:0]          req_parity_type,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [NUM_REQ-1:0]          req_done,
    input  logic                        tx_busy,
    output logic [in_width-1:0]         tx_parallel_data,
    output logic                        tx_data_vaild,
    output logic                        tx_parity_en,
    output logic                        tx_parity_type,
    output logic [IDW-1:0]              active_id,
    output logic                        sched_busy,
    output logic                        tx_err
);

    localparam int TW = $clog2(BUSY_TIMEOUT);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [7:0]           gap_cnt_q, gap_cnt_d;
    logic [IDW-1:0]       active_id_q, active_id_d;
    logic [in_width-1:0]  tx_parallel_data_q, tx_parallel_data_d;
    logic                 tx_parity_en_q, tx_parity_en_d;
    logic                 tx_parity_type_q, tx_parity_type_d;
    logic                 tx_data_vaild_q, tx_data_vaild_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]   req_done_q, req_done_d;
    logic                 tx_err_q, tx_err_d;
    logic                 sched_busy_q, sched_busy_d;

    logic                 grant_valid;
    logic [IDW-1:0]       grant_id;
    logic                 launch;
    logic                 timer_expired;

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    assign timer_expired = (timer_q == TW'(BUSY_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q            <= S_IDLE;
            rr_ptr_q           <= '0;
            timer_q            <= '0;
            gap_cnt_q          <= '0;
            active_id_q        <= '0;
            tx_parallel_data_q <= '0;
            tx_parity_en_q     <= 1'b0;
            tx_parity_type_q   <= 1'b0;
            tx_data_vaild_q    <= 1'b0;
            req_ack_q          <= '0;
            req_done_q         <= '0;
            tx_err_q           <= 1'b0;
            sched_busy_q       <= 1'b0;
        end else begin
            state_q            <= state_d;
            rr_ptr_q           <= rr_ptr_d;
            timer_q            <= timer_d;
            gap_cnt_q          <= gap_cnt_d;
            active_id_q        <= active_id_d;
            tx_parallel_data_q <= tx_parallel_data_d;
            tx_parity_en_q     <= tx_parity_en_d;
            tx_parity_type_q   <= tx_parity_type_d;
            tx_data_vaild_q    <= tx_data_vaild_d;
            req_ack_q          <= req_ack_d;
            req_done_q         <= req_done_d;
            tx_err_q           <= tx_err_d;
            sched_busy_q       <= sched_busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_valid && !tx_busy) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_d = S_WAIT_BUSY;
                timer_d = '0;
            end
            S_WAIT_BUSY: begin
                if (tx_busy)            state_d = S_WAIT_DONE;
                else if (timer_expired) state_d = S_IDLE;
                else                    timer_d = timer_q + TW'(1);
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = 8'(GAP_CYCLES);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q <= 8'd1) state_d = S_IDLE;
                else                   gap_cnt_d = gap_cnt_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed one edge early so every port comes straight from a flop.
    always_comb begin
        launch             = (state_q == S_IDLE) && (state_d == S_LAUNCH);
        rr_ptr_d           = rr_ptr_q;
        active_id_d        = active_id_q;
        tx_parallel_data_d = tx_parallel_data_q;
        tx_parity_en_d     = tx_parity_en_q;
        tx_parity_type_d   = tx_parity_type_q;
        tx_data_vaild_d    = 1'b0;
        req_ack_d          = '0;
        if (launch) begin
            tx_parallel_data_d = req_data[int'(grant_id)*in_width +: in_width];
            tx_parity_en_d     = req_parity_en[grant_id];
            tx_parity_type_d   = req_parity_type[grant_id];
            active_id_d        = grant_id;
            rr_ptr_d           = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
            tx_data_vaild_d    = 1'b1;
            req_ack_d          = ONE_HOT0 << grant_id;
        end
        req_done_d   = ((state_q == S_WAIT_DONE) && !tx_busy) ? (ONE_HOT0 << active_id_q) : '0;
        tx_err_d     = (state_q == S_WAIT_BUSY) && !tx_busy && timer_expired;
        sched_busy_d = (state_d != S_IDLE);
    end

    assign req_ack          = req_ack_q;
    assign req_done         = req_done_q;
    assign tx_parallel_data = tx_parallel_data_q;
    assign tx_data_vaild    = tx_data_vaild_q;
    assign tx_parity_en     = tx_parity_en_q;
    assign tx_parity_type   = tx_parity_type_q;
    assign active_id        = active_id_q;
    assign sched_busy       = sched_busy_q;
    assign tx_err           = tx_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - scoreboard bench for uart_tx_scheduler with a simple TX Busy model
module tb_uart_tx_scheduler;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int GAP = 3;
    localparam int TO  = 16;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   req_data = {8'hD4, 8'h3C, 8'h5A, 8'hA5};
    logic [N-1:0]     req_parity_en = 4'b0101;
    logic [N-1:0]     req_parity_type = 4'b1010;
    logic [N-1:0]     req_ack;
    logic [N-1:0]     req_done;
    logic             tx_busy = 1'b0;
    logic [W-1:0]     tx_parallel_data;
    logic             tx_data_vaild;
    logic             tx_parity_en;
    logic             tx_parity_type;
    logic [IDW-1:0]   active_id;
    logic             sched_busy;
    logic             tx_err;

    uart_tx_scheduler #(
        .in_width    (W),
        .NUM_REQ     (N),
        .GAP_CYCLES  (GAP),
        .BUSY_TIMEOUT(TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_data        (req_data),
        .req_parity_en   (req_parity_en),
        .req_parity_type (req_parity_type),
        .req_ack         (req_ack),
        .req_done        (req_done),
        .tx_busy         (tx_busy),
        .tx_parallel_data(tx_parallel_data),
        .tx_data_vaild   (tx_data_vaild),
        .tx_parity_en    (tx_parity_en),
        .tx_parity_type  (tx_parity_type),
        .active_id       (active_id),
        .sched_busy      (sched_busy),
        .tx_err          (tx_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       pe;
        logic       pt;
    } exp_t;

    exp_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int launches = 0;
    int last_launch_cyc = 0;
    int last_done_cyc = 0;
    int dones = 0;
    int errs = 0;
    bit model_en = 1'b1;
    bit force_busy = 1'b0;
    int busy_start = -1;
    int busy_end = -1;
    bit done_pending = 1'b0;
    bit err_pending = 1'b0;
    int exp_done_cyc = 0;
    int exp_done_id = 0;
    int exp_err_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic exp_t mk(input int i);
        exp_t e;
        e.id   = i;
        e.data = req_data[i*W +: W];
        e.pe   = req_parity_en[i];
        e.pt   = req_parity_type[i];
        return e;
    endfunction

    // One clock: sample just after the edge, score, then drive requester and TX model inputs.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (tx_data_vaild) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_launch", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("launch_id", 32'(active_id), e.id);
                chk("launch_data", 32'(tx_parallel_data), 32'(e.data));
                chk("launch_par_en", 32'(tx_parity_en), 32'(e.pe));
                chk("launch_par_type", 32'(tx_parity_type), 32'(e.pt));
                chk("launch_ack", 32'(req_ack), 32'(1) << e.id);
            end
            launches++;
            last_launch_cyc = cyc;
            if (model_en) begin
                busy_start   = cyc + 2;
                busy_end     = cyc + 7;
                done_pending = 1'b1;
                exp_done_cyc = busy_end + 1;
                exp_done_id  = int'(active_id);
            end else begin
                err_pending = 1'b1;
                exp_err_cyc = cyc + TO + 1;
            end
        end else if (req_ack != '0) begin
            chk("ack_without_launch", 32'(req_ack), 32'd0);
        end
        if (done_pending && cyc == exp_done_cyc) begin
            chk("done_vec", 32'(req_done), 32'(1) << exp_done_id);
            done_pending  = 1'b0;
            dones++;
            last_done_cyc = cyc;
        end else if (req_done != '0) begin
            chk("spurious_done", 32'(req_done), 32'd0);
        end
        if (err_pending && cyc == exp_err_cyc) begin
            chk("tx_err", 32'(tx_err), 32'd1);
            chk("err_sched_idle", 32'(sched_busy), 32'd0);
            err_pending = 1'b0;
            errs++;
        end else if (tx_err) begin
            chk("spurious_err", 32'(tx_err), 32'd0);
        end
        req     = req & ~req_ack;
        tx_busy = force_busy || (model_en && cyc >= busy_start && cyc < busy_end);
    endtask

    task automatic wait_launches(input int n, input int budget, input string tag);
        int target;
        int k;
        target = launches + n;
        k = 0;
        while (launches < target && k < budget) begin
            step();
            k++;
        end
        chk(tag, launches, target);
    endtask

    task automatic wait_quiet(input int budget, input string tag);
        int k;
        k = 0;
        while ((sched_busy || done_pending || err_pending || exp_q.size() != 0) && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(k < budget), 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ack"}, 32'(req_ack), 32'd0);
        chk({tag, "_done"}, 32'(req_done), 32'd0);
        chk({tag, "_data"}, 32'(tx_parallel_data), 32'd0);
        chk({tag, "_ctl"}, 32'({tx_data_vaild, tx_parity_en, tx_parity_type, active_id, sched_busy, tx_err}), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        chk_reset("reset");
        rst          = 1'b1;
        done_pending = 1'b0;
        err_pending  = 1'b0;
        busy_end     = cyc;
        tx_busy      = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int t;
        int l0;
        int r;

        step();
        step();
        do_reset();
        step();

        // Single request: ack/launch one cycle after req, done after Busy falls.
        exp_q.push_back(mk(0));
        t = cyc;
        req = 4'b0001;
        wait_launches(1, 10, "t1_launch");
        chk("t1_latency", last_launch_cyc, t + 1);
        wait_quiet(40, "t1_quiet");
        chk("t1_done_count", dones, 1);

        // Two pending requesters with the gap enforced between frames (rr_ptr is now 1).
        exp_q.push_back(mk(1));
        exp_q.push_back(mk(0));
        req = 4'b0011;
        wait_launches(1, 10, "t5_first");
        wait_launches(1, 40, "t5_second");
        chk("t5_gap_launch", last_launch_cyc - last_done_cyc, GAP + 1);
        wait_quiet(40, "t5_quiet");

        // Busy held high while idle blocks the launch until it is sampled low.
        exp_q.push_back(mk(1));
        force_busy = 1'b1;
        tx_busy    = 1'b1;
        req        = 4'b0010;
        l0         = launches;
        repeat (6) step();
        chk("t3_no_launch", launches, l0);
        force_busy = 1'b0;
        tx_busy    = 1'b0;
        r          = cyc;
        wait_launches(1, 10, "t3_launch");
        chk("t3_latency", last_launch_cyc, r + 1);
        wait_quiet(40, "t3_quiet");

        // All four requesting from a fresh pointer; requester 0 asks again after its ack.
        do_reset();
        exp_q.push_back(mk(0));
        exp_q.push_back(mk(1));
        exp_q.push_back(mk(2));
        exp_q.push_back(mk(3));
        exp_q.push_back(mk(0));
        req = 4'b1111;
        wait_launches(1, 10, "t2_first");
        req[0] = 1'b1;
        wait_launches(4, 200, "t2_rest");
        wait_quiet(60, "t2_quiet");

        // Busy never rises: timeout error, no done.
        model_en = 1'b0;
        t = dones;
        exp_q.push_back(mk(1));
        req = 4'b0010;
        wait_launches(1, 10, "t4_launch");
        wait_quiet(60, "t4_quiet");
        chk("t4_err_count", errs, 1);
        chk("t4_no_done", dones, t);
        model_en = 1'b1;

        // Reset in the middle of a frame; the next grant scans from index 0 again.
        exp_q.push_back(mk(2));
        req = 4'b0100;
        wait_launches(1, 10, "t6_launch");
        repeat (4) step();
        chk("t6_in_frame", 32'(sched_busy), 32'd1);
        do_reset();
        exp_q.push_back(mk(1));
        req = 4'b1010;
        wait_launches(1, 10, "t6_regrant");
        chk("t6_regrant_id", 32'(active_id), 32'd1);
        req = 4'b0000;
        wait_quiet(40, "t6_quiet");

        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
